// File: rtl/cmpx_div_seq.sv
// Sequential complex divider: q = (a+jb)/(c+jd), quotient in Q(M+1).F, truncated toward zero.
// Two restoring dividers run in parallel on |Re(N)|<<F and |Im(N)|<<F, one bit per cycle.
module cmpx_div_seq #(
    parameter int M = 8,
    parameter int F = 7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [M-1:0] num_real,
    input  logic signed [M-1:0] num_imag,
    input  logic signed [M-1:0] den_real,
    input  logic signed [M-1:0] den_imag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [M+F:0] q_real,
    output logic signed [M+F:0] q_imag,
    output logic                div_by_zero
);

    localparam int W  = M + F + 1;
    localparam int R  = 2 * M + 1;
    localparam int NS = 2 * M + F;
    localparam int CW = $clog2(NS);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic signed [M-1:0]   a_q, b_q, c_q, d_q;
    logic [R-1:0]          dd_q;
    logic [R-1:0]          rem_q [2];
    logic [NS-1:0]         sh_q  [2];
    logic                  neg_q [2];
    logic                  zero_q;
    logic                  in_ready_q, out_valid_q, dbz_q;
    logic signed [W-1:0]   q_real_q, q_imag_q;

    logic signed [R-1:0]   ax, bx, cx, dx, nr, ni, dd;
    logic [R-1:0]          nabs  [2];
    logic [R:0]            trial [2];
    logic [R-1:0]          sub   [2];
    logic [R-1:0]          rem_d [2];
    logic [NS-1:0]         sh_d  [2];
    logic                  ge    [2];
    logic [W-1:0]          qmag  [2];
    logic [W-1:0]          qres  [2];

    always_comb begin
        ax = {{(R-M){a_q[M-1]}}, a_q};
        bx = {{(R-M){b_q[M-1]}}, b_q};
        cx = {{(R-M){c_q[M-1]}}, c_q};
        dx = {{(R-M){d_q[M-1]}}, d_q};
        nr = ax * cx + bx * dx;
        ni = bx * cx - ax * dx;
        dd = cx * cx + dx * dx;
        nabs[0] = nr[R-1] ? -nr : nr;
        nabs[1] = ni[R-1] ? -ni : ni;
    end

    // Dividend bits leave sh_q at the top while quotient bits enter at the bottom.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            trial[i] = {rem_q[i], sh_q[i][NS-1]};
            ge[i]    = trial[i] >= {1'b0, dd_q};
            sub[i]   = trial[i][R-1:0] - dd_q;
            rem_d[i] = ge[i] ? sub[i] : trial[i][R-1:0];
            sh_d[i]  = {sh_q[i][NS-2:0], ge[i]};
            qmag[i]  = sh_q[i][W-1:0];
            qres[i]  = neg_q[i] ? -qmag[i] : qmag[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_real_q    <= '0;
            q_imag_q    <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= num_real;
                        b_q        <= num_imag;
                        c_q        <= den_real;
                        d_q        <= den_imag;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    dd_q   <= dd;
                    zero_q <= (dd == '0);
                    cnt_q  <= '0;
                    for (int unsigned i = 0; i < 2; i++) begin
                        neg_q[i] <= (i == 0) ? nr[R-1] : ni[R-1];
                        // |N| <= 2^(2M-1), so its top bit is always the first (zero) quotient bit.
                        rem_q[i] <= {{(R-1){1'b0}}, nabs[i][R-1]};
                        sh_q[i]  <= {nabs[i][R-2:0], {F{1'b0}}};
                    end
                    // A zero divisor skips DIV but still passes through FIX, giving a 2-edge latency.
                    state_q <= (dd == '0) ? FIX : DIV;
                end
                DIV: begin
                    for (int unsigned i = 0; i < 2; i++) begin
                        rem_q[i] <= rem_d[i];
                        sh_q[i]  <= sh_d[i];
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NS - 1)) state_q <= FIX;
                end
                FIX: begin
                    q_real_q    <= zero_q ? '0 : qres[0];
                    q_imag_q    <= zero_q ? '0 : qres[1];
                    dbz_q       <= zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign q_real      = q_real_q;
    assign q_imag      = q_imag_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cmpx_div_seq.sv
// Directed and random checks of cmpx_div_seq against an integer model of trunc(N*2^F/D).
module tb_cmpx_div_seq;

    localparam int M = 8;
    localparam int F = 7;
    localparam int W = M + F + 1;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [M-1:0] num_real = '0, num_imag = '0, den_real = '0, den_imag = '0;
    logic                in_ready, out_valid, div_by_zero;
    logic signed [W-1:0] q_real, q_imag;

    typedef struct {
        int qr;
        int qi;
        int dz;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    cmpx_div_seq #(.M(M), .F(F)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .num_real(num_real), .num_imag(num_imag),
        .den_real(den_real), .den_imag(den_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_real(q_real), .q_imag(q_imag), .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int c, input int d);
        exp_t e;
        int nr, ni, dd;
        nr = a * c + b * d;
        ni = b * c - a * d;
        dd = c * c + d * d;
        if (dd == 0) begin
            e.qr = 0; e.qi = 0; e.dz = 1;
        end else begin
            e.qr = (nr * (1 << F)) / dd;
            e.qi = (ni * (1 << F)) / dd;
            e.dz = 0;
        end
        return e;
    endfunction

    task automatic accept(input int a, input int b, input int c, input int d);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge CLK); #1; t++;
        end
        chk("accept_ready", 32'(in_ready), 1);
        num_real = 8'(a); num_imag = 8'(b); den_real = 8'(c); den_imag = 8'(d);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        sb.push_back(model(a, b, c, d));
        accept(a, b, c, d);
    endtask

    task automatic collect(input string tag, input int exp_lat, input int stall, input bit poke);
        exp_t e;
        int   lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge CLK); #1; lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
            e.qr = 0; e.qi = 0; e.dz = 0;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, "_q_real"}, q_real, e.qr);
        chk({tag, "_q_imag"}, q_imag, e.qi);
        chk({tag, "_dbz"}, 32'(div_by_zero), e.dz);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                num_real = 8'(s * 13 - 50); den_real = 8'(s + 1);
                in_valid = s[0];
            end
            @(posedge CLK); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 1);
            chk({tag, "_hold_q_real"}, q_real, e.qr);
            chk({tag, "_hold_q_imag"}, q_imag, e.qi);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 32'(out_valid), 0);
        chk({tag, "_release_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int a, b, c, d;

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_q_real", q_real, 0);
        chk("rst_q_imag", q_imag, 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // basic scaling and latency
        send(64, 0, 2, 0);       collect("t1", 25, 0, 1'b0);
        send(10, 10, 10, -10);   collect("t2a", 25, 1, 1'b0);
        send(-7, 0, 2, 0);       collect("t2b", 25, 0, 1'b0);
        // truncation toward zero and extreme magnitude
        send(1, 0, 3, 0);        collect("t3a", 25, 0, 1'b0);
        send(-1, 0, 3, 0);       collect("t3b", 25, 0, 1'b0);
        send(-128, -128, 1, 1);  collect("t3c", 25, 0, 1'b0);
        send(-128, -128, -128, -128); collect("t3d", 25, 0, 1'b0);
        // divide by zero, then cleared by the next op
        send(5, 3, 0, 0);        collect("t4a", 2, 0, 1'b0);
        send(9, -4, 3, 1);       collect("t4b", 25, 0, 1'b0);
        // long stall with ignored in_valid pulses
        send(100, -50, 7, 3);    collect("t5", 25, 10, 1'b1);
        send(-33, 77, -5, 12);   collect("t5b", 25, 0, 1'b0);

        // reset mid-DIV aborts with no output
        accept(3, 4, 1, 2);
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_q_real", q_real, 0);
        chk("t6_q_imag", q_imag, 0);
        repeat (30) @(posedge CLK);
        #1;
        chk("t6_no_output", 32'(out_valid), 0);
        send(3, 4, 1, 2);        collect("t6b", 25, 0, 1'b0);

        // random operands with random output stalls
        for (int n = 0; n < 24; n++) begin
            a = $signed(8'($urandom));
            b = $signed(8'($urandom));
            c = (n % 8 == 7) ? 0 : $signed(8'($urandom));
            d = (n % 8 == 7) ? 0 : $signed(8'($urandom));
            send(a, b, c, d);
            collect("rnd", (c == 0 && d == 0) ? 2 : 25, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
